// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle restoring divider for DIV/DIVU.
// Produces one quotient bit per clock, writes the quotient (LO) to q and
// the remainder (HI) to r, and pulses over for one cycle when they are valid.
module iter_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             over
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic             r_signMode;
    logic             r_dividendNeg;
    logic             r_divisorNeg;
    logic [WIDTH-1:0] r_dividendRaw;
    logic [WIDTH-1:0] r_divMag;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_dividendMag;
    logic [WIDTH-1:0] w_divisorMag;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_remNext;
    logic [WIDTH-1:0] w_quoNext;
    logic [WIDTH-1:0] w_qFinal;
    logic [WIDTH-1:0] w_rFinal;
    logic             w_lastStep;

    // Operand magnitudes taken at start; the most-negative value maps to
    // its own bit pattern, which is the correct unsigned magnitude.
    always_comb begin
        w_dividendMag = dividend;
        w_divisorMag  = divisor;
        if (sign && dividend[WIDTH-1]) begin
            w_dividendMag = '0 - dividend;
        end
        if (sign && divisor[WIDTH-1]) begin
            w_divisorMag = '0 - divisor;
        end
    end

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    // magnitude, keep the difference and set the new quotient bit if it fits.
    always_comb begin
        w_shifted = {r_rem, r_quo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, r_divMag};
        w_remNext = w_shifted[WIDTH-1:0];
        w_quoNext = {r_quo[WIDTH-2:0], 1'b0};
        if (!w_diff[WIDTH]) begin
            w_remNext    = w_diff[WIDTH-1:0];
            w_quoNext[0] = 1'b1;
        end
    end

    // Final result: divide-by-zero bypasses the sign fix and returns the
    // raw dividend as remainder; otherwise truncate toward zero with the
    // remainder carrying the dividend's sign.
    always_comb begin
        w_lastStep = (r_count == CW'(WIDTH - 1));
        w_qFinal   = w_quoNext;
        w_rFinal   = w_remNext;
        if (r_divMag == '0) begin
            w_qFinal = '1;
            w_rFinal = r_dividendRaw;
        end else if (r_signMode) begin
            if (r_dividendNeg != r_divisorNeg) begin
                w_qFinal = '0 - w_quoNext;
            end
            if (r_dividendNeg) begin
                w_rFinal = '0 - w_remNext;
            end
        end
    end

    // Control FSM and datapath registers; q/r only change on completion.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_signMode    <= 1'b0;
            r_dividendNeg <= 1'b0;
            r_divisorNeg  <= 1'b0;
            r_dividendRaw <= '0;
            r_divMag      <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_count       <= '0;
            busy          <= 1'b0;
            over          <= 1'b0;
            q             <= '0;
            r             <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    over <= 1'b0;
                    if (start) begin
                        r_signMode    <= sign;
                        r_dividendNeg <= sign & dividend[WIDTH-1];
                        r_divisorNeg  <= sign & divisor[WIDTH-1];
                        r_dividendRaw <= dividend;
                        r_divMag      <= w_divisorMag;
                        r_quo         <= w_dividendMag;
                        r_rem         <= '0;
                        r_count       <= '0;
                        busy          <= 1'b1;
                        r_state       <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_rem   <= w_remNext;
                    r_quo   <= w_quoNext;
                    r_count <= r_count + 1'b1;
                    if (w_lastStep) begin
                        busy    <= 1'b0;
                        over    <= 1'b1;
                        q       <= w_qFinal;
                        r       <= w_rFinal;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    over    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_div_unit.sv
// tb_iter_div_unit: directed checks of the iterative divider, covering
// unsigned/signed results, boundary operands, ignored restarts, async
// abort and back-to-back operations.
module tb_iter_div_unit;

    logic        clk_in;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        over;

    int errors;
    int checks;

    iter_div_unit #(.WIDTH(32)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .start    (start),
        .sign     (sign),
        .dividend (dividend),
        .divisor  (divisor),
        .q        (q),
        .r        (r),
        .busy     (busy),
        .over     (over)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle; returns just after the capturing edge.
    task automatic applyStimulus(input logic s, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk_in);
        start    = 1'b1;
        sign     = s;
        dividend = a;
        divisor  = b;
        @(negedge clk_in);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
    endtask

    // Called just after the capturing edge: expects 32 busy-only cycles,
    // then the over cycle with the result. Optionally pokes start at
    // busy cycles 5 and 20 with different operands.
    task automatic waitRun(input string tag, input logic [31:0] expQ,
                           input logic [31:0] expR, input bit poke);
        int busyCount;
        busyCount = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy === 1'b1 && over === 1'b0) busyCount++;
            if (poke && (i == 5 || i == 20)) begin
                start    = 1'b1;
                sign     = 1'b0;
                dividend = 32'd999;
                divisor  = 32'd10;
            end else begin
                start = 1'b0;
            end
            @(negedge clk_in);
        end
        start = 1'b0;
        checkOutput({tag, "_busyCycles"}, 32'(busyCount), 32'd32);
        checkOutput({tag, "_over"}, {31'd0, over}, 32'd1);
        checkOutput({tag, "_busyInOver"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_q"}, q, expQ);
        checkOutput({tag, "_r"}, r, expR);
    endtask

    task automatic checkOverDrop(input string tag);
        @(negedge clk_in);
        checkOutput({tag, "_overLow"}, {31'd0, over}, 32'd0);
        checkOutput({tag, "_idleBusy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int overSeen;
        errors   = 0;
        checks   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;

        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_over", {31'd0, over}, 32'd0);
        checkOutput("rst_q", q, 32'd0);
        checkOutput("rst_r", r, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;

        applyStimulus(1'b0, 32'd100, 32'd7);
        waitRun("u100_7", 32'd14, 32'd2, 1'b0);
        checkOverDrop("u100_7");

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        waitRun("sNeg7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        checkOverDrop("sNeg7_2");

        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        waitRun("s7_neg2", 32'hFFFF_FFFD, 32'd1, 1'b0);
        checkOverDrop("s7_neg2");

        applyStimulus(1'b0, 32'd5, 32'd0);
        waitRun("u5_0", 32'hFFFF_FFFF, 32'd5, 1'b0);
        checkOverDrop("u5_0");

        applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd0);
        waitRun("sNeg5_0", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);

        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitRun("sOvf", 32'h8000_0000, 32'd0, 1'b0);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        waitRun("uMax_1", 32'hFFFF_FFFF, 32'd0, 1'b0);

        applyStimulus(1'b0, 32'd100, 32'd7);
        waitRun("ignStart", 32'd14, 32'd2, 1'b1);
        checkOverDrop("ignStart");

        // Abort in the middle of a run; outputs must clear without a clock edge.
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clk_in);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_over", {31'd0, over}, 32'd0);
        checkOutput("abort_q", q, 32'd0);
        checkOutput("abort_r", r, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        overSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (over !== 1'b0 || busy !== 1'b0) overSeen++;
        end
        checkOutput("abort_noOver", 32'(overSeen), 32'd0);

        applyStimulus(1'b0, 32'd9, 32'd3);
        waitRun("u9_3", 32'd3, 32'd0, 1'b0);
        checkOverDrop("u9_3");

        // Back-to-back: op B's start is presented during op A's over cycle.
        applyStimulus(1'b0, 32'd20, 32'd6);
        waitRun("b2bA", 32'd3, 32'd2, 1'b0);
        start    = 1'b1;
        sign     = 1'b0;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk_in);
        start    = 1'b0;
        checkOutput("b2bB_overLow", {31'd0, over}, 32'd0);
        checkOutput("b2bB_busyStart", {31'd0, busy}, 32'd1);
        checkOutput("b2bB_qHeld", q, 32'd3);
        waitRun("b2bB", 32'd10, 32'd0, 1'b0);
        checkOverDrop("b2bB");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
